// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer. It accepts words over valid/ready
// and shifts them out one bit per clock, with sof/eof framing strobes. Back-to-back words stream gap-free.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_vld_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic             hvld_q, hvld_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] sh_next;

  // Shift toward whichever end feeds x_o.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
    end else begin : g_msb
      assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_comb begin
    accept   = valid_i && !hvld_q;
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    load     = hvld_q && ((state_q == IDLE) || last_bit);

    state_d = state_q;
    hbuf_d  = hbuf_q;
    hvld_d  = hvld_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;

    // accept needs hvld_q=0 and load needs hvld_q=1, so they never collide
    if (accept) begin
      hbuf_d = data_i;
      hvld_d = 1'b1;
    end

    if (load) begin
      sh_d    = hbuf_q;
      cnt_d   = '0;
      state_d = SHIFT;
      hvld_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        sh_d  = sh_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      hbuf_q  <= '0;
      hvld_q  <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hbuf_q  <= hbuf_d;
      hvld_q  <= hvld_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ready_o = !hvld_q;
    busy_o  = (state_q == SHIFT) || hvld_q;
    x_o     = IDLE_VAL;
    x_vld_o = 1'b0;
    sof_o   = 1'b0;
    eof_o   = 1'b0;
    if (state_q == SHIFT) begin
      x_o     = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
      x_vld_o = 1'b1;
      sof_o   = (cnt_q == '0);
      eof_o   = (cnt_q == LAST_CNT);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1) with
// scoreboard queues filled on accept and drained by per-instance bit monitors.
module tb_piso_serializer;

  typedef struct packed {
    logic x;
    logic sof;
    logic eof;
    logic cont;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] data0, data1;
  logic       valid0, valid1;
  logic       rdy0, x0, xv0, sof0, eof0, busy0;
  logic       rdy1, x1, xv1, sof1, eof1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  bit   prev0 = 1'b0;
  bit   prev1 = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .data_i(data0), .valid_i(valid0), .ready_o(rdy0),
    .x_o(x0), .x_vld_o(xv0), .sof_o(sof0), .eof_o(eof0), .busy_o(busy0)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .data_i(data1), .valid_i(valid1), .ready_o(rdy1),
    .x_o(x1), .x_vld_o(xv1), .sof_o(sof1), .eof_o(eof1), .busy_o(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Offer word w to instance d; garbage is driven while ready is low and must be ignored.
  task automatic send(input int d, input logic [3:0] w, input bit hold, input bit cont_last);
    int   t;
    logic r;
    exp_t e;
    t = 0;
    @(negedge clk);
    r = (d == 0) ? rdy0 : rdy1;
    while (!r && t < 50) begin
      if (d == 0) begin data0 = ~w; valid0 = 1'b1; end
      else        begin data1 = ~w; valid1 = 1'b1; end
      @(negedge clk);
      r = (d == 0) ? rdy0 : rdy1;
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'(r), 32'd1);
    if (d == 0) begin data0 = w; valid0 = 1'b1; end
    else        begin data1 = w; valid1 = 1'b1; end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      e.x    = (d == 0) ? w[3-i] : w[i];
      e.sof  = (i == 0);
      e.eof  = (i == 3);
      e.cont = (i == 3) ? cont_last : 1'b1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    $display("accept dut%0d word %b at %0t", d, w, $time);
    #1;
    if (d == 0) begin data0 = hold ? 4'hF : 4'h0; valid0 = hold; end
    else        begin data1 = hold ? 4'hF : 4'h0; valid1 = hold; end
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((d == 0) ? busy0 : busy1) && t < 40);
    chk("drain_timeout", 32'(t < 40), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (xv0) begin
        if (q0.size() == 0) begin
          chk("dut0_unexpected_bit", 32'(xv0), 32'd0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("dut0_x", 32'(x0), 32'(e.x));
          chk("dut0_sof", 32'(sof0), 32'(e.sof));
          chk("dut0_eof", 32'(eof0), 32'(e.eof));
          prev0 = e.cont;
        end
      end else begin
        chk("dut0_idle_x", 32'(x0), 32'd0);
        if (prev0) chk("dut0_gap", 32'(xv0), 32'd1);
        prev0 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (xv1) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_bit", 32'(xv1), 32'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("dut1_x", 32'(x1), 32'(e.x));
          chk("dut1_sof", 32'(sof1), 32'(e.sof));
          chk("dut1_eof", 32'(eof1), 32'(e.eof));
          prev1 = e.cont;
        end
      end else begin
        chk("dut1_idle_x", 32'(x1), 32'd1);
        if (prev1) chk("dut1_gap", 32'(xv1), 32'd1);
        prev1 = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = 4'h0;  data1 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_x0", 32'(x0), 32'd0);
    chk("rst_xvld0", 32'(xv0), 32'd0);
    chk("rst_sof0", 32'(sof0), 32'd0);
    chk("rst_eof0", 32'(eof0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_x1", 32'(x1), 32'd1);
    chk("rst_xvld1", 32'(xv1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    #2 rstn = 1'b1;

    // single word with latency: held one cycle, then first bit after the load edge
    send(0, 4'b1011, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_wait_xvld", 32'(xv0), 32'd0);
    chk("t1_wait_ready", 32'(rdy0), 32'd0);
    chk("t1_wait_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("t1_first_xvld", 32'(xv0), 32'd1);
    chk("t1_first_sof", 32'(sof0), 32'd1);
    chk("t1_ready_back", 32'(rdy0), 32'd1);
    drain(0);
    chk("t1_end_x", 32'(x0), 32'd0);
    chk("t1_end_xvld", 32'(xv0), 32'd0);
    chk("t1_end_busy", 32'(busy0), 32'd0);

    // back-to-back stream: 1,0,1,1,0,1,1,0 with no gap
    send(0, 4'b1011, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_ready_after_accept", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("t2_ready_after_load", 32'(rdy0), 32'd1);
    data0 = 4'b0110;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      q0.push_back('{x: data0[3-i], sof: (i == 0), eof: (i == 3), cont: 1'b0});
    $display("accept dut0 word %b at %0t", data0, $time);
    #1 valid0 = 1'b0;
    drain(0);

    // backpressure: three words with valid held, garbage while not ready
    send(0, 4'b1001, 1'b1, 1'b1);
    send(0, 4'b0101, 1'b1, 1'b1);
    send(0, 4'b1110, 1'b0, 1'b0);
    drain(0);

    // LSB first: 1011 -> 1,1,0,1; then a 3-cycle gap on the IDLE_VAL=1 instance
    send(1, 4'b1011, 1'b0, 1'b0);
    drain(1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_gap_x1", 32'(x1), 32'd1);
      chk("t5_gap_xvld1", 32'(xv1), 32'd0);
    end
    send(1, 4'b0100, 1'b0, 1'b0);
    drain(1);

    // reset mid-word while a second word is held
    send(0, 4'b1011, 1'b1, 1'b1);
    send(0, 4'b0111, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_held_busy", 32'(busy0), 32'd1);
    chk("t6_held_ready", 32'(rdy0), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(rdy0), 32'd1);
    chk("t6_rst_x", 32'(x0), 32'd0);
    chk("t6_rst_xvld", 32'(xv0), 32'd0);
    chk("t6_rst_sof", 32'(sof0), 32'd0);
    chk("t6_rst_eof", 32'(eof0), 32'd0);
    chk("t6_rst_busy", 32'(busy0), 32'd0);
    q0.delete();
    prev0 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_post_ready", 32'(rdy0), 32'd1);
    chk("t6_post_busy", 32'(busy0), 32'd0);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
